// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU on port 0, DMA on port 1) with misalignment flagging.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_rd,
  input  logic [3:0]        p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_rd,
  input  logic [3:0]        p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_rd,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              act0, act1, win, sel1, w_rd, mis;
  logic [3:0]        w_we;
  logic              pend_valid, pend_port;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Byte lanes below the start offset mean the access wraps past the word end.
  function automatic logic misaligned(input logic rd, input logic [3:0] we,
                                      input logic [1:0] off);
    logic m;
    case (off)
      2'd0:    m = 1'b0;
      2'd1:    m = rd | we[0];
      2'd2:    m = rd | (|we[1:0]);
      default: m = rd | (|we[2:0]);
    endcase
    return m;
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic last_port;

  always_ff @(posedge clk) begin
    if (rst)      last_port <= 1'b1;
    else if (win) last_port <= sel1;
  end
`endif

  always_comb begin
    act0 = ~rst & p0_req & (p0_rd | (|p0_we));
    act1 = ~rst & p1_req & (p1_rd | (|p1_we));
    win  = act0 | act1;
`ifdef DMEM_ARB_RR_EN
    sel1 = act1 & (~act0 | ~last_port);
`else
    sel1 = act1 & ~act0;
`endif
    w_rd      = sel1 ? p1_rd    : p0_rd;
    w_we      = sel1 ? p1_we    : p0_we;
    mem_addr  = sel1 ? p1_addr  : p0_addr;
    mem_wdata = sel1 ? p1_wdata : p0_wdata;
    mis       = win & misaligned(w_rd, w_we, mem_addr[1:0]);
    p0_gnt    = act0 & ~sel1;
    p1_gnt    = sel1;
    mem_rd    = win & ~mis & w_rd;
    mem_we    = (win & ~mis) ? w_we : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      pend_valid <= mem_rd;
      pend_port  <= sel1;
      p0_err     <= mis & ~sel1;
      p1_err     <= mis & sel1;
      if (pend_valid && !pend_port) rdata0_q <= mem_rdata;
      if (pend_valid &&  pend_port) rdata1_q <= mem_rdata;
    end
  end

  // Read data passes straight through in the return cycle and is held afterwards.
  assign p0_rvalid = pend_valid & ~pend_port;
  assign p1_rvalid = pend_valid &  pend_port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : rdata0_q;
  assign p1_rdata  = p1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the data memory, sharing its single read/write port between the CPU load/store unit (port 0) and the loader/debug DMA master (port 1). Each cycle it selects at most one request, drives the memory port combinationally, and routes the registered read data back to the port that issued the read one cycle later. The arbitration policy (round-robin or fixed priority) is fixed at compile time. The block also flags misaligned accesses.

## Interface
Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width; the block supports only 32.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- p0_req  in  1  port 0 (CPU) request valid.
- p0_rd  in  1  port 0 read access.
- p0_we  in  4  port 0 byte write enables; bit n enables byte n.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle; combinational.
- p0_rvalid  out  1  port 0 read data valid; registered.
- p0_rdata  out  DATA_W  port 0 read data.
- p0_err  out  1  port 0 misaligned access; registered one-cycle pulse.
- p1_req, p1_rd, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as the p0_* set, for port 1 (DMA).
- mem_rd  out  1  read strobe to the data memory.
- mem_we  out  4  byte write enables to the data memory.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_wdata  out  DATA_W  write data to the data memory.
- mem_rdata  in  DATA_W  data memory output; registered in memory, valid the cycle after mem_rd.

## Operation
- A request is active when pN_req=1 and (pN_rd | (|pN_we))=1. A request with neither a read nor a write is ignored: no grant and no error.
- A requester holds rd, we, addr and wdata stable from raising req until it sees gnt. pN_req=1 with gnt=1 in the same cycle is a transfer.
- Requests with both rd and we set are legal. The memory performs both, and the read returns the old contents.
- Selection each cycle:
  - Only one port active: that port wins.
  - Both ports active: the policy in Configuration applies.
  - Exactly one gnt is high per cycle, or none.
- Memory drive, combinational from the winner:
  - mem_addr = winner addr; mem_wdata = winner wdata.
  - mem_rd = winner rd; mem_we = winner we.
  - With no winner: mem_rd=0, mem_we=0, and mem_addr/mem_wdata hold the port 0 values.
- Alignment check:
  - A granted access is misaligned if addr[1:0]!=0 and the byte-enable pattern crosses the word boundary, or if a read has addr[1:0]!=0.
  - A misaligned access is still granted, but the block forces mem_rd=0 and mem_we=0 for it.
  - pN_err pulses the following cycle. A misaligned read produces no rvalid.
- Read return tracking:
  - State is a 1-bit pend_valid and a 1-bit pend_port, both registered when a read is issued.
  - The next cycle, p[pend_port]_rvalid=1 and its rdata = mem_rdata.
  - The other port's rdata stays at its last value.
- Back-to-back accesses are allowed with no bubbles. The block sustains one access per cycle, and responses stay in issue order.

## Timing
- Grant: combinational, the same cycle as req.
- Memory strobe: the same cycle as the grant.
- Read latency: rvalid and rdata arrive exactly 1 cycle after the grant.
- Write latency: the write is committed at the posedge ending the grant cycle. No write acknowledge beyond gnt.
- err: 1 cycle after the grant.
- Reset values while rst=1:
  - p0_gnt, p1_gnt, mem_rd and mem_we are forced to 0.
  - The cycle after rst deasserts: p0/p1_rvalid=0, p0/p1_err=0, p0/p1_rdata=0, pend_valid=0, last_port=1 (so port 0 wins the first tie).
- Reset mid-operation: a read granted in the cycle rst rises returns no rvalid. Requesters re-issue.
- Simultaneous events: a response to port X and a grant to port Y in the same cycle are independent and both occur.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin.
  - The last_port register updates to the winner on every grant.
  - On a tie, the port not equal to last_port wins.
  - Two continuously requesting ports alternate 0,1,0,1.
- DMEM_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins a tie, and port 1 is granted only in cycles where port 0 is not active.
  - The last_port register is not implemented.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to 0x10 with we=4'hF, then p0 reads 0x10 -> p0_gnt=1 both cycles; the cycle after the read grant, p0_rvalid=1 and p0_rdata=0xDEADBEEF; p1_rvalid stays 0.
- Both ports read continuously for 6 cycles (p0 at 0x0, p1 at 0x4) -> with DMEM_ARB_RR_EN, grants go p0,p1,p0,p1,p0,p1 and each rvalid follows its grant by 1 cycle; without it, p0 is granted 6 times and p1 0 times.
- p1 byte write we=4'b0100, wdata=0x00AB0000 to 0x20 (prior contents 0x11223344), then a read -> p1_rdata=0x11AB3344.
- p0 read at 0x22 -> p0_gnt=1, mem_rd=0, p0_err=1 the next cycle, no p0_rvalid; a p0 half write we=4'b1100 to 0x22 is accepted with no err.
- p0 read granted, with rst asserted in the same cycle -> no p0_rvalid after reset; all outputs at their reset values; the first tie after reset grants p0.
- p0_req=1 with rd=0 and we=0 while p1 reads -> p1 is granted every cycle; p0_gnt=0 and p0_err=0.
